bootram_ctrl: RTL
=================

// Module: bootram_ctrl
// PURPOSE
//  Controller for the 32-bit boot RAM built from four 2Kx8 single-port byte-lane BRAMs (lane i = bits 8i+7:8i).
//  Arbitrates between the CPU native memory port (valid/ready/wstrb) and the byte-wide boot loader port.
//  Sequences each BRAM access and applies a CPU write-protect lock.
//  Sits between the SoC address decoder / loader and the four bootram_2kx8_N lanes.
// PARAMETERS
//  ADDR_W    11   word-address width; RAM depth = 2**ADDR_W words
//  WP_RESET  1    value loaded into write-protect flag at reset
// PORTS
//  clk        in   1         system clock
//  reset      in   1         asynchronous, active-high reset
//  cpu_valid  in   1         CPU request; held stable until cpu_ready
//  cpu_addr   in   32        byte address; only [ADDR_W+1:2] used
//  cpu_wdata  in   32        write data
//  cpu_wstrb  in   4         byte strobes; 0 = read
//  cpu_rdata  out  32        read data; valid only when cpu_ready=1, else 0
//  cpu_ready  out  1         one-cycle completion pulse
//  ld_valid   in   1         loader byte-write request; held until ld_ready
//  ld_addr    in   ADDR_W+2  loader byte address
//  ld_data    in   8         loader byte
//  ld_ready   out  1         loader accept, same cycle as the write
//  wp_set     in   1         pulse: set write-protect
//  wp_clr     in   1         pulse: clear write-protect
//  wp         out  1         current write-protect state
//  wp_viol    out  1         one-cycle pulse: CPU write dropped by wp
//  ram_ce     out  1         BRAM clock enable (shared by all lanes)
//  ram_oce    out  1         BRAM output CE; equals ram_ce
//  ram_wre    out  4         per-lane write enable
//  ram_ad     out  ADDR_W    word address (shared by all lanes)
//  ram_din    out  32        write data, lane-packed
//  ram_dout   in   32        read data from lanes; valid 1 cycle after a read ce
// BEHAVIOUR
//  - FSM states: IDLE, RD_DATA, WR_ACK. Reset -> IDLE. All outputs are 0 except wp=WP_RESET.
//  - The reset input is asynchronous: asserting it mid-access drops cpu_ready/ram_* immediately. The in-flight access is lost.
//  - RAM control outputs are combinational from state and the granted request. The RAM RESET pins are tied to 0 at top level.
//  - IDLE arbitration is fixed priority: loader > CPU. There is no preemption. ld_valid is ignored in RD_DATA/WR_ACK.
//  - Loader grant (IDLE, ld_valid=1):
//      - ram_ce=1, ram_ad=ld_addr[ADDR_W+1:2], ram_din={4{ld_data}}.
//      - ram_wre=one-hot(ld_addr[1:0]), ld_ready=1. State stays IDLE.
//      - Back-to-back bytes are accepted every cycle. wp does not apply to the loader.
//  - CPU read (IDLE, no ld_valid, cpu_valid=1, wstrb=0):
//      - ram_ce=1, ram_wre=0, ram_ad=cpu_addr[ADDR_W+1:2]; go to RD_DATA.
//      - In RD_DATA: cpu_ready=1, cpu_rdata=ram_dout; go to IDLE.
//      - Latency: ready 1 cycle after grant.
//  - CPU write (wstrb!=0):
//      - ram_ce=1, ram_din=cpu_wdata. ram_wre=cpu_wstrb if wp=0, else 4'b0000 and wp_viol=1 that cycle.
//      - Go to WR_ACK. In WR_ACK: cpu_ready=1; go to IDLE. A blocked write is still acknowledged.
//  - cpu_valid is sampled again only in IDLE. The requester deasserts it after the ready cycle.
//  - wp register: wp_set and wp_clr in the same cycle -> set wins. A change takes effect for grants on the next cycle.
//  - Address wrap: upper cpu_addr bits are ignored (aliasing). Decoding is done upstream.
// TESTING
//  1 Reset asserted -> cpu_ready=ld_ready=ram_ce=ram_wre=0, cpu_rdata=0, wp=1.
//  2 Lane preload word 5 = 0x11223344; CPU read addr 0x14 -> ram_ad=5 in T0, cpu_ready=1 and rdata=0x11223344 in T1.
//  3 wp_clr; CPU write addr 0x14, wdata 0xAABBCCDD, wstrb 4'b0010 -> ram_wre=4'b0010, ready in T1; readback = 0x1122CC44.
//  4 wp_set; CPU write addr 0x14, wstrb 4'b1111 -> ram_wre=0, wp_viol pulse, ready in T1; readback unchanged.
//  5 ld_valid and cpu_valid both high, loader bytes 0xA0..0xA3 to addr 0..3 on consecutive cycles:
//      - ld_ready each cycle, CPU waits; CPU is then served.
//      - Word 0 = 0xA3A2A1A0.
//  6 reset asserted during RD_DATA -> cpu_ready falls without waiting for a clock edge.
//      - After release the FSM is in IDLE and the held cpu_valid is re-served with the correct rdata.

Source files
------------

// File: rtl/bootram_ctrl.sv
// Boot RAM controller: loader/CPU arbitration over four byte-lane BRAMs with CPU write-protect.
// Loader byte writes are accepted in the same cycle; CPU read/write completes one cycle after grant.
module bootram_ctrl #(
    parameter int   ADDR_W   = 11,
    parameter logic WP_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_valid,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W+1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    input  logic              wp_set,
    input  logic              wp_clr,
    output logic              wp,
    output logic              wp_viol,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic [3:0]        ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    typedef enum logic [1:0] {
        IDLE,
        RD_DATA,
        WR_ACK
    } state_t;

    state_t state, state_nxt;
    logic   wp_q;

    // Upper address bits alias and byte offset is irrelevant for word access.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            wp_q  <= WP_RESET;
        end else begin
            state <= state_nxt;
            if (wp_set)
                wp_q <= 1'b1;
            else if (wp_clr)
                wp_q <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        cpu_rdata = '0;
        cpu_ready = 1'b0;
        ld_ready  = 1'b0;
        wp_viol   = 1'b0;
        ram_ce    = 1'b0;
        ram_wre   = 4'b0000;
        ram_ad    = '0;
        ram_din   = '0;
        // Outputs are forced quiet while reset is held, regardless of pending requests.
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (ld_valid) begin
                        ram_ce   = 1'b1;
                        ram_ad   = ld_addr[ADDR_W+1:2];
                        ram_din  = {4{ld_data}};
                        ram_wre  = 4'b0001 << ld_addr[1:0];
                        ld_ready = 1'b1;
                    end else if (cpu_valid) begin
                        ram_ce = 1'b1;
                        ram_ad = cpu_addr[ADDR_W+1:2];
                        if (cpu_wstrb == 4'b0000) begin
                            state_nxt = RD_DATA;
                        end else begin
                            ram_din   = cpu_wdata;
                            ram_wre   = wp_q ? 4'b0000 : cpu_wstrb;
                            wp_viol   = wp_q;
                            state_nxt = WR_ACK;
                        end
                    end
                end
                RD_DATA: begin
                    cpu_ready = 1'b1;
                    cpu_rdata = ram_dout;
                    state_nxt = IDLE;
                end
                WR_ACK: begin
                    cpu_ready = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign wp      = wp_q;
    assign ram_oce = ram_ce;

endmodule
